uart_autobaud_ctrl: RTL and testbench

Configuration controller for the UART baud rate generator. On request it measures a 0x55 sync character on the receive line, derives the 16-bit baud divisor, and programs the generator. It also accepts a direct software divisor write. Whenever the divisor changes it pulses a generator reset so that rx_tick/tx_tick realign. Sits between the CSR block, the RX pin and the baud rate generator's baud_divisor/reset inputs.

---
 rtl/uart_autobaud_ctrl_if.sv | 24 ++
 rtl/uart_autobaud_ctrl.sv | 179 +++++++++++++++++
 tb/tb_uart_autobaud_ctrl.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_autobaud_ctrl_if.sv
// Purpose: bundles the auto-baud controller's CSR, RX pin and baud generator signals.
// Ports: master = CSR/pin side (drives rx_in, start, sw_wr, sw_divisor);
//        slave  = controller (drives baud_divisor, gen_reset, busy, done, error).
interface uart_autobaud_ctrl_if;
    logic        rx_in;
    logic        start;
    logic        sw_wr;
    logic [15:0] sw_divisor;
    logic [15:0] baud_divisor;
    logic        gen_reset;
    logic        busy;
    logic        done;
    logic        error;

    modport master (
        output rx_in, start, sw_wr, sw_divisor,
        input  baud_divisor, gen_reset, busy, done, error
    );

    modport slave (
        input  rx_in, start, sw_wr, sw_divisor,
        output baud_divisor, gen_reset, busy, done, error
    );
endinterface

// File: rtl/uart_autobaud_ctrl.sv
// Purpose: measures a 0x55 sync char on rx_in (or takes a software write) and programs the baud divisor.
// Latency: 3-cycle rx edge detect; CALC 1 cycle after the 5th fall; gen_reset held 2 cycles after any divisor change.
// Backpressure: none; start/sw_wr are single-cycle strobes honoured only in IDLE, otherwise dropped.
// Ports: clk, reset_n (async active-low), bus (slave modport of uart_autobaud_ctrl_if).
module uart_autobaud_ctrl #(
    parameter logic [15:0]      DEFAULT_DIVISOR = 16'd868,
    parameter logic [15:0]      MIN_DIVISOR     = 16'd32,
    parameter int               CNT_W           = 20,
    parameter logic [CNT_W-1:0] TIMEOUT_CYCLES  = 20'hFFFFF
) (
    input  logic                 clk,
    input  logic                 reset_n,
    uart_autobaud_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {
        S_IDLE, S_WAIT_FALL, S_MEASURE, S_CALC, S_APPLY, S_FAIL
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = 1;
    localparam logic [CNT_W:0]   RND      = 4;
    localparam logic [CNT_W:0]   DIV_MAX  = 'hFFFF;
    localparam logic [CNT_W:0]   DIV_MIN  = {{(CNT_W-15){1'b0}}, MIN_DIVISOR};

    state_t           state_q, state_d;
    logic             rx_s1_q, rx_s1_d;
    logic             rx_s2_q, rx_s2_d;
    logic             rx_prev_q, rx_prev_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] ivl_q, ivl_d;
    logic [CNT_W-1:0] ref_q, ref_d;
    logic [CNT_W-1:0] total_q, total_d;
    logic [2:0]       edge_cnt_q, edge_cnt_d;
    logic             apply_cnt_q, apply_cnt_d;
    logic [15:0]      div_q, div_d;
    logic             rst_hold_q, rst_hold_d;

    logic             fall;
    logic [CNT_W-1:0] ik;
    logic [CNT_W-1:0] diff;
    logic             mismatch;
    logic [CNT_W:0]   div_wide;
    logic             div_ok;

    // Counters stick at all-ones rather than wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_ONE;
    endfunction

    // Same synchronizer latency on every edge, so it cancels out of the intervals.
    assign fall     = rx_prev_q & ~rx_s2_q;
    // Interval ends on the fall cycle itself, hence the +1.
    assign ik       = sat_inc(ivl_q);
    assign diff     = (ik >= ref_q) ? (ik - ref_q) : (ref_q - ik);
    assign mismatch = diff > (ref_q >> 2);
    // 8 bit times measured; +4 before >>3 rounds to nearest.
    assign div_wide = ({1'b0, total_q} + RND) >> 3;
    assign div_ok   = (div_wide <= DIV_MAX) && (div_wide >= DIV_MIN);

    assign bus.baud_divisor = div_q;
    assign bus.busy         = (state_q != S_IDLE);
    assign bus.done         = (state_q == S_CALC) && div_ok;
    assign bus.error        = (state_q == S_FAIL);
    // rst_hold_q keeps the generator in reset through our own reset and one clk after.
    assign bus.gen_reset    = rst_hold_q | (state_q == S_APPLY);

    always_comb begin
        state_d     = state_q;
        rx_s1_d     = bus.rx_in;
        rx_s2_d     = rx_s1_q;
        rx_prev_d   = rx_s2_q;
        timer_d     = timer_q;
        ivl_d       = ivl_q;
        ref_d       = ref_q;
        total_d     = total_q;
        edge_cnt_d  = edge_cnt_q;
        apply_cnt_d = apply_cnt_q;
        div_d       = div_q;
        rst_hold_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.sw_wr) begin
                    div_d       = bus.sw_divisor;
                    apply_cnt_d = 1'b0;
                    state_d     = S_APPLY;
                end else if (bus.start) begin
                    timer_d = CNT_ZERO;
                    state_d = S_WAIT_FALL;
                end
            end
            S_WAIT_FALL: begin
                if (fall) begin
                    timer_d    = CNT_ZERO;
                    ivl_d      = CNT_ZERO;
                    ref_d      = CNT_ZERO;
                    edge_cnt_d = 3'd0;
                    state_d    = S_MEASURE;
                end else if (timer_q >= TIMEOUT_CYCLES) begin
                    state_d = S_FAIL;
                end else begin
                    timer_d = sat_inc(timer_q);
                end
            end
            S_MEASURE: begin
                timer_d = sat_inc(timer_q);
                ivl_d   = sat_inc(ivl_q);
                if (fall) begin
                    ivl_d      = CNT_ZERO;
                    edge_cnt_d = edge_cnt_q + 3'd1;
                    if (edge_cnt_q == 3'd0) begin
                        ref_d = ik;
                    end else if (mismatch) begin
                        state_d = S_FAIL;
                    end else if (edge_cnt_q == 3'd3) begin
                        total_d = sat_inc(timer_q);
                        state_d = S_CALC;
                    end
                end else if (timer_q >= TIMEOUT_CYCLES) begin
                    state_d = S_FAIL;
                end
            end
            S_CALC: begin
                if (div_ok) begin
                    div_d       = div_wide[15:0];
                    apply_cnt_d = 1'b0;
                    state_d     = S_APPLY;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_APPLY: begin
                if (apply_cnt_q) begin
                    state_d = S_IDLE;
                end else begin
                    apply_cnt_d = 1'b1;
                end
            end
            S_FAIL: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            rx_s1_q     <= 1'b1;
            rx_s2_q     <= 1'b1;
            rx_prev_q   <= 1'b1;
            timer_q     <= '0;
            ivl_q       <= '0;
            ref_q       <= '0;
            total_q     <= '0;
            edge_cnt_q  <= 3'd0;
            apply_cnt_q <= 1'b0;
            div_q       <= DEFAULT_DIVISOR;
            rst_hold_q  <= 1'b1;
        end else begin
            state_q     <= state_d;
            rx_s1_q     <= rx_s1_d;
            rx_s2_q     <= rx_s2_d;
            rx_prev_q   <= rx_prev_d;
            timer_q     <= timer_d;
            ivl_q       <= ivl_d;
            ref_q       <= ref_d;
            total_q     <= total_d;
            edge_cnt_q  <= edge_cnt_d;
            apply_cnt_q <= apply_cnt_d;
            div_q       <= div_d;
            rst_hold_q  <= rst_hold_d;
        end
    end

endmodule

// File: tb/tb_uart_autobaud_ctrl.sv
// Bench for uart_autobaud_ctrl: directed byte waveforms, expected events queued by stimulus,
// a negedge monitor pops and compares on every done/error pulse and gen_reset window.
module tb_uart_autobaud_ctrl;
    localparam logic [19:0] TO = 20'd8000;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    uart_autobaud_ctrl_if bus();

    uart_autobaud_ctrl #(.TIMEOUT_CYCLES(TO)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    typedef enum int {EV_DONE, EV_ERR, EV_APPLY} ev_t;
    typedef struct {
        ev_t         kind;
        logic [15:0] div;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          err_cyc = 0;
    int          start_cyc = 0;
    bit          apply_active = 0;
    int          apply_len = 0;
    logic        gr_prev = 1'b1;
    logic [15:0] cur_div = 16'd868;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, expv);
        end
    endtask

    task automatic mon_event(input ev_t k, input logic [15:0] d);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event: got kind=%0d div=%0d expected nothing at cycle %0d", k, d, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.div !== d) begin
                bad++;
                $display("FAIL event_order: got kind=%0d div=%0d expected kind=%0d div=%0d", k, d, e.kind, e.div);
            end
        end
    endtask

    // Monitor: every output event must match the head of the expectation queue.
    always @(negedge clk) begin
        if (!reset_n) begin
            gr_prev      = 1'b1;
            apply_active = 0;
        end else begin
            if (bus.done) mon_event(EV_DONE, bus.baud_divisor);
            if (bus.error) begin
                err_cyc = cyc;
                mon_event(EV_ERR, bus.baud_divisor);
            end
            if (bus.gen_reset && !gr_prev) begin
                mon_event(EV_APPLY, bus.baud_divisor);
                apply_active = 1;
                apply_len    = 0;
            end
            if (apply_active) begin
                if (bus.gen_reset) begin
                    apply_len++;
                end else begin
                    chk("gen_reset_len", apply_len, 2);
                    chk("busy_after_apply", bus.busy, 0);
                    apply_active = 0;
                end
            end
            gr_prev = bus.gen_reset;
        end
    end

    task automatic expect_meas(input logic [15:0] nd);
        exp_q.push_back('{EV_DONE, cur_div});
        exp_q.push_back('{EV_APPLY, nd});
        cur_div = nd;
    endtask

    task automatic expect_err();
        exp_q.push_back('{EV_ERR, cur_div});
    endtask

    task automatic do_start();
        @(negedge clk);
        start_cyc = cyc;
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
    endtask

    // 8N1, LSB first, t clk per bit, then a short idle gap.
    task automatic send_byte(input logic [7:0] b, input int t);
        bus.rx_in = 1'b0;
        repeat (t) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            bus.rx_in = b[i];
            repeat (t) @(negedge clk);
        end
        bus.rx_in = 1'b1;
        repeat (t) @(negedge clk);
        repeat (20) @(negedge clk);
    endtask

    task automatic wait_idle(input string name);
        bit ok;
        ok = 0;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0 && !apply_active && !bus.busy) begin
                ok = 1;
                break;
            end
        end
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: timed out with %0d events pending, busy=%0b", name, exp_q.size(), bus.busy);
            exp_q.delete();
        end
    endtask

    initial begin
        #4_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        bus.rx_in      = 1'b1;
        bus.start      = 1'b0;
        bus.sw_wr      = 1'b0;
        bus.sw_divisor = 16'd0;
        reset_n        = 1'b0;
        #23;
        chk("rst_divisor", bus.baud_divisor, 868);
        chk("rst_gen_reset", bus.gen_reset, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_error", bus.error, 0);
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("gen_reset_release", bus.gen_reset, 0);

        // 0x55 at 868 clk/bit
        expect_meas(16'd868);
        do_start();
        chk("busy_wait_fall", bus.busy, 1);
        send_byte(8'h55, 868);
        wait_idle("meas_868");
        chk("div_868", bus.baud_divisor, 868);

        // 0x55 at 434, then 437 (total 3496 -> 437)
        expect_meas(16'd434);
        do_start();
        send_byte(8'h55, 434);
        wait_idle("meas_434");
        chk("div_434", bus.baud_divisor, 434);
        expect_meas(16'd437);
        do_start();
        send_byte(8'h55, 437);
        wait_idle("meas_437");
        chk("div_437", bus.baud_divisor, 437);

        // line held high: timeout after TO+2 edges counted from the start sample
        expect_err();
        do_start();
        wait_idle("timeout");
        chk("timeout_cycle", err_cyc - start_cyc, 32'(TO) + 2);
        chk("div_after_timeout", bus.baud_divisor, 437);

        // too fast: divisor 3 < MIN_DIVISOR
        expect_err();
        do_start();
        send_byte(8'h55, 3);
        wait_idle("too_fast");
        chk("div_after_fast", bus.baud_divisor, 437);

        // 0x45: third interval is twice the reference
        expect_err();
        do_start();
        send_byte(8'h45, 437);
        wait_idle("bad_pattern");
        chk("div_after_0x45", bus.baud_divisor, 437);

        // sw_wr wins over start in the same cycle
        @(negedge clk);
        exp_q.push_back('{EV_APPLY, 16'd1736});
        cur_div        = 16'd1736;
        bus.sw_wr      = 1'b1;
        bus.sw_divisor = 16'd1736;
        bus.start      = 1'b1;
        @(negedge clk);
        bus.sw_wr = 1'b0;
        bus.start = 1'b0;
        chk("sw_div_next", bus.baud_divisor, 1736);
        chk("sw_gen_reset", bus.gen_reset, 1);
        wait_idle("sw_write");
        repeat (10) @(negedge clk);
        chk("sw_no_measure", bus.busy, 0);

        // sw_wr during MEASURE is ignored
        expect_meas(16'd434);
        do_start();
        fork
            send_byte(8'h55, 434);
        join_none
        repeat (1500) @(negedge clk);
        bus.sw_wr      = 1'b1;
        bus.sw_divisor = 16'd100;
        @(negedge clk);
        bus.sw_wr = 1'b0;
        wait fork;
        wait_idle("sw_in_measure");
        chk("div_ignore_sw", bus.baud_divisor, 434);

        // async reset in the middle of MEASURE
        do_start();
        fork
            send_byte(8'h55, 868);
        join_none
        repeat (3000) @(negedge clk);
        chk("busy_mid_measure", bus.busy, 1);
        #2 reset_n = 1'b0;
        #1;
        chk("midrst_divisor", bus.baud_divisor, 868);
        chk("midrst_gen_reset", bus.gen_reset, 1);
        chk("midrst_busy", bus.busy, 0);
        chk("midrst_done", bus.done, 0);
        chk("midrst_error", bus.error, 0);
        wait fork;
        cur_div = 16'd868;
        @(negedge clk);
        #2 reset_n = 1'b1;
        @(negedge clk);
        chk("midrst_release", bus.gen_reset, 0);

        // measurement works again after the reset
        expect_meas(16'd437);
        do_start();
        send_byte(8'h55, 437);
        wait_idle("meas_after_reset");
        chk("div_after_reset", bus.baud_divisor, 437);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
